// File: rtl/cmp.sv
// -----------------------------------------------------------------------------
// cmp: branch comparator evaluated on funct3-style compare codes.
//
// Purpose:
//   Pure combinational compare of two operands. The result is 1 when the
//   selected relation holds.
//
// Ports:
//   op     in  3      compare code (beq/bne/blt/bge/bltu/bgeu)
//   a      in  WIDTH  operand A
//   b      in  WIDTH  operand B
//   taken  out 1      relation result
// -----------------------------------------------------------------------------
module cmp #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        taken = 1'b0;
        unique case (op)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt_s;
            3'b101:  taken = ~lt_s;
            3'b110:  taken = lt_u;
            // bgeu, plus the unused codes 010/011 which fall back to
            // unsigned greater-or-equal.
            default: taken = ~lt_u;
        endcase
    end

endmodule

// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter: shares one cmp comparator between two requesters.
//
// Purpose:
//   Port 0 carries branch resolution, port 1 carries slt/sltu. A round-robin
//   arbiter grants one request at a time, latches its operands, runs the
//   comparator from the latched values, and returns the result on the
//   granted port's response channel with a valid/ready handshake.
//   Sequence per transaction: IDLE (grant) -> COMPARE -> RESP (until taken).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   reqN_valid/op/a/b        request from requester N (N = 0,1)
//   reqN_ready               request accepted this cycle (IDLE, granted port)
//   respN_valid/out          result for requester N, out is 0 unless valid
//   respN_ready              requester N consumes the result
// -----------------------------------------------------------------------------
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             resp0_valid,
    output logic             resp0_out,
    input  logic             resp0_ready,

    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp1_valid,
    output logic             resp1_out,
    input  logic             resp1_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             rr_ptr_reg, rr_ptr_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             id_reg;
    logic             result_reg;

    logic [1:0]       req_valid;
    logic [1:0]       resp_ready;
    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_out;

    logic             grant_any;
    logic             grant_id;
    logic [2:0]       grant_op;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             cmp_taken;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    // Round-robin pick: a lone requester always wins; on contention the
    // pointer decides. rr_ptr is flipped after every completed response, so
    // two continuously valid requesters alternate.
    assign grant_any = |req_valid;
    assign grant_id  = (&req_valid) ? rr_ptr_reg : req_valid[1];
    assign grant_op  = grant_id ? req1_op : req0_op;
    assign grant_a   = grant_id ? req1_a  : req0_a;
    assign grant_b   = grant_id ? req1_b  : req0_b;

    cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .op    (op_reg),
        .a     (a_reg),
        .b     (b_reg),
        .taken (cmp_taken)
    );

    // State register and pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Operand latch and result register. Operands are captured only on the
    // accept edge, so requester-side changes afterwards are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg     <= 3'd0;
            a_reg      <= '0;
            b_reg      <= '0;
            id_reg     <= 1'b0;
            result_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && grant_any) begin
                op_reg <= grant_op;
                a_reg  <= grant_a;
                b_reg  <= grant_b;
                id_reg <= grant_id;
            end
            if (state_reg == COMPARE) begin
                result_reg <= cmp_taken;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        unique case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                state_next = RESP;
            end
            RESP: begin
                // Only the owning port's ready completes the handshake.
                if (resp_ready[id_reg]) begin
                    state_next  = IDLE;
                    rr_ptr_next = ~id_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic. req_ready is masked by rst so every output reads 0 for
    // the whole time reset is held, even though the state already sits in
    // IDLE and a request may be pending.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        resp_out   = 2'b00;
        unique case (state_reg)
            IDLE: begin
                if (grant_any && !rst) begin
                    req_ready[grant_id] = 1'b1;
                end
            end
            RESP: begin
                resp_valid[id_reg] = 1'b1;
                resp_out[id_reg]   = result_reg;
            end
            default: begin
            end
        endcase
    end

    assign req0_ready  = req_ready[0];
    assign req1_ready  = req_ready[1];
    assign resp0_valid = resp_valid[0];
    assign resp1_valid = resp_valid[1];
    assign resp0_out   = resp_out[0];
    assign resp1_out   = resp_out[1];

endmodule
